// File: rtl/dpram_axi_pkg.sv
// rtl/dpram_axi_pkg.sv - response codes and FSM encoding shared across the dpram_axi subsystem
package dpram_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RESP = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/axi_lite_ram_port.sv
// rtl/axi_lite_ram_port.sv - AXI4-Lite slave driving RAM port A with one command per transaction
// Optional address range check: define AXI_RAM_ADDR_CHECK_EN.
module axi_lite_ram_port
    import dpram_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19,
    parameter int MEM_DEPTH  = 1 << 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_e                state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  w_strb_q, w_strb_d;
    logic                  ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  rr_wr_first_q, rr_wr_first_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_err_q, rd_err_d;

    logic wr_err, rd_err;
    logic wr_pend, rd_pend, wr_sel, rd_sel;
    logic ram_en_c, ram_we_c;

`ifdef AXI_RAM_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
    assign wr_err = {1'b0, aw_addr_q} >= DEPTH_W;
    assign rd_err = {1'b0, ar_addr_q} >= DEPTH_W;
`else
    logic unused_mem_depth;
    assign unused_mem_depth = MEM_DEPTH[0];
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // Readies and the RAM enable are forced low while reset is held so nothing leaks out mid-reset.
    assign s_awready = rst & ~aw_full_q;
    assign s_wready  = rst & ~w_full_q;
    assign s_arready = rst & ~ar_full_q;
    assign s_bvalid  = (state_q == ST_WR_RESP);
    assign s_rvalid  = (state_q == ST_RD_RESP);
    assign s_bresp   = bresp_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign ram_en    = ram_en_c & rst;
    assign ram_we    = ram_we_c & rst;

    assign wr_pend = aw_full_q & w_full_q;
    assign rd_pend = ar_full_q;
    assign wr_sel  = wr_pend & (~rd_pend | rr_wr_first_q);
    assign rd_sel  = rd_pend & ~wr_sel;

    always_comb begin
        state_d       = state_q;
        aw_full_d     = aw_full_q;
        aw_addr_d     = aw_addr_q;
        w_full_d      = w_full_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        ar_full_d     = ar_full_q;
        ar_addr_d     = ar_addr_q;
        rr_wr_first_d = rr_wr_first_q;
        rdata_d       = rdata_q;
        bresp_d       = bresp_q;
        rresp_d       = rresp_q;
        rd_err_d      = rd_err_q;
        ram_en_c      = 1'b0;
        ram_we_c      = 1'b0;
        ram_addr      = aw_addr_q;
        ram_wdata     = w_data_q;

        if (s_awvalid && s_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (s_arvalid && s_arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_araddr;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_pend && rd_pend) begin
                    rr_wr_first_d = ~rr_wr_first_q;
                end
                if (wr_sel) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    ram_en_c  = ~wr_err;
                    ram_we_c  = w_strb_q & ~wr_err;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                    state_d   = ST_WR_RESP;
                end else if (rd_sel) begin
                    ar_full_d = 1'b0;
                    ram_en_c  = ~rd_err;
                    ram_addr  = ar_addr_q;
                    rd_err_d  = rd_err;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_WR_RESP: begin
                if (s_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                rdata_d = rd_err_q ? '0 : ram_rdata;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            aw_full_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_full_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= 1'b0;
            ar_full_q     <= 1'b0;
            ar_addr_q     <= '0;
            rr_wr_first_q <= 1'b1;
            rdata_q       <= '0;
            bresp_q       <= RESP_OKAY;
            rresp_q       <= RESP_OKAY;
            rd_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_full_q     <= aw_full_d;
            aw_addr_q     <= aw_addr_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            ar_full_q     <= ar_full_d;
            ar_addr_q     <= ar_addr_d;
            rr_wr_first_q <= rr_wr_first_d;
            rdata_q       <= rdata_d;
            bresp_q       <= bresp_d;
            rresp_q       <= rresp_d;
            rd_err_q      <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_port.sv
// tb/tb_axi_lite_ram_port.sv - directed bench for axi_lite_ram_port with a behavioural RAM on port A
module tb_axi_lite_ram_port;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid, s_awready;
    logic [DW-1:0] s_wdata;
    logic          s_wstrb, s_wvalid, s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid, s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid, s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid, s_rready;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    axi_lite_ram_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    logic [DW-1:0] mem [0:1023];
    int            cyc = 0;
    int            op_cnt = 0;
    int            last_grant = 0;
    logic          last_we;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    logic [AW-1:0] op_addr_log [0:255];
    logic          op_we_log   [0:255];
    int            n_cmp = 0;
    int            n_bad = 0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_rdata = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[9:0]];
        end
    end

    always @(negedge clk) begin
        if (ram_en) begin
            op_addr_log[op_cnt[7:0]] = ram_addr;
            op_we_log[op_cnt[7:0]]   = ram_we;
            last_we    = ram_we;
            last_addr  = ram_addr;
            last_wdata = ram_wdata;
            last_grant = cyc;
            op_cnt     = op_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tfail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    function automatic bit oob(input logic [AW-1:0] a);
`ifdef AXI_RAM_ADDR_CHECK_EN
        return a >= 19'd1024;
`else
        return 1'b0;
`endif
    endfunction

    // Holds each requested valid until its handshake; returns on the negedge after the last one.
    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [AW-1:0] awa, input logic [DW-1:0] wd, input logic ws,
                         input logic [AW-1:0] ara);
        int  n;
        bit  aw_hs, w_hs, ar_hs;
        if (do_aw) begin s_awaddr = awa; s_awvalid = 1'b1; end
        if (do_w)  begin s_wdata = wd; s_wstrb = ws; s_wvalid = 1'b1; end
        if (do_ar) begin s_araddr = ara; s_arvalid = 1'b1; end
        n = 0;
        while ((s_awvalid || s_wvalid || s_arvalid) && n < 40) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            ar_hs = s_arvalid && s_arready;
            @(negedge clk);
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid  = 1'b0;
            if (ar_hs) s_arvalid = 1'b0;
            n++;
        end
        if (n >= 40) begin
            tfail("issue");
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
            s_arvalid = 1'b0;
        end
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input bit chk_lat);
        int n = 0;
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        if (!s_bvalid) tfail("bvalid");
        else begin
            chk("bresp", s_bresp, exp_resp);
            if (chk_lat) chk("b_latency", cyc - last_grant, 1);
            @(negedge clk);
        end
    endtask

    task automatic wait_r(input logic [DW-1:0] exp_data, input logic [1:0] exp_resp, input bit chk_lat);
        int n = 0;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        if (!s_rvalid) tfail("rvalid");
        else begin
            chk("rdata", s_rdata, exp_data);
            chk("rresp", s_rresp, exp_resp);
            if (chk_lat) chk("r_latency", cyc - last_grant, 2);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          strb;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int       op0;
        bit       bad;
        logic [1:0] er;
        logic [DW-1:0] ed;

        vecs[0] = '{1'b1, 19'h00010, 8'hA5, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 19'h00010, 8'h00, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 19'h00030, 8'h11, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 19'h00030, 8'hFF, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 19'h00030, 8'h00, 1'b0, 8'h11};
        vecs[5] = '{1'b1, 19'h7FFFF, 8'h5A, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 19'h7FFFF, 8'h00, 1'b0, 8'h5A};
        vecs[7] = '{1'b1, 19'h00001, 8'hC3, 1'b1, 8'h00};
        vecs[8] = '{1'b0, 19'h00001, 8'h00, 1'b0, 8'hC3};
        vecs[9] = '{1'b0, 19'h00010, 8'h00, 1'b0, 8'hA5};

        rst = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = 1'b0; s_wvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", s_awready, 1);
        chk("post_rst_arready", s_arready, 1);

        for (int i = 0; i < 10; i++) begin
            bad = oob(vecs[i].addr);
            er  = bad ? SLVERR : OKAY;
            ed  = bad ? 8'h00 : vecs[i].exp_data;
            op0 = op_cnt;
            if (vecs[i].wr) begin
                issue(1'b1, 1'b1, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].strb, '0);
                wait_b(er, !bad);
                if (bad) chk("wr_suppressed", op_cnt, op0);
                else begin
                    chk("wr_op_count", op_cnt, op0 + 1);
                    chk("wr_ram_we", last_we, vecs[i].strb);
                    chk("wr_ram_addr", last_addr, vecs[i].addr);
                    chk("wr_ram_wdata", last_wdata, vecs[i].data);
                end
            end else begin
                issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, vecs[i].addr);
                wait_r(ed, er, !bad);
            end
        end

        // W leads AW by three cycles: no RAM access until the address arrives.
        op0 = op_cnt;
        issue(1'b0, 1'b1, 1'b0, '0, 8'h3C, 1'b1, '0);
        repeat (3) @(negedge clk);
        chk("w_only_no_op", op_cnt, op0);
        chk("w_only_no_bvalid", s_bvalid, 0);
        issue(1'b1, 1'b0, 1'b0, 19'h00020, '0, 1'b0, '0);
        wait_b(OKAY, 1'b1);
        chk("w_first_op_count", op_cnt, op0 + 1);
        chk("w_first_addr", last_addr, 19'h00020);
        chk("w_first_mem", mem[10'h020], 8'h3C);

        // Simultaneous write and read after reset: write first, then the pointer favours the read.
        do_reset();
        op0 = op_cnt;
        issue(1'b1, 1'b1, 1'b1, 19'h00040, 8'h77, 1'b1, 19'h00050);
        repeat (8) @(negedge clk);
        chk("arb1_op_count", op_cnt, op0 + 2);
        chk("arb1_first_addr", op_addr_log[op0[7:0]], 19'h00040);
        chk("arb1_first_we", op_we_log[op0[7:0]], 1);
        chk("arb1_second_addr", op_addr_log[(op0 + 1) & 255], 19'h00050);
        op0 = op_cnt;
        issue(1'b1, 1'b1, 1'b1, 19'h00060, 8'h88, 1'b1, 19'h00040);
        repeat (8) @(negedge clk);
        chk("arb2_op_count", op_cnt, op0 + 2);
        chk("arb2_first_addr", op_addr_log[op0[7:0]], 19'h00040);
        chk("arb2_first_we", op_we_log[op0[7:0]], 0);
        chk("arb2_second_addr", op_addr_log[(op0 + 1) & 255], 19'h00060);
        chk("arb2_mem", mem[10'h060], 8'h88);

        // Read response stalled by rready; a second AR is captured meanwhile.
        s_rready = 1'b0;
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h00010);
        begin
            int n = 0;
            while (!s_rvalid && n < 10) begin @(negedge clk); n++; end
        end
        chk("stall_rvalid_up", s_rvalid, 1);
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h00030);
        for (int k = 0; k < 10; k++) begin
            chk("stall_rvalid", s_rvalid, 1);
            chk("stall_rdata", s_rdata, 8'hA5);
            chk("stall_arready", s_arready, 0);
            @(negedge clk);
        end
        s_rready = 1'b1;
        @(negedge clk);
        wait_r(8'h11, OKAY, 1'b1);

        // Reset while the read is waiting on RAM data.
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h00010);
        chk("rstmid_grant", ram_en, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_awready", s_awready, 0);
        chk("rstmid_wready", s_wready, 0);
        chk("rstmid_arready", s_arready, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstmid_rvalid", s_rvalid, 0);
            chk("rstmid_bvalid", s_bvalid, 0);
            chk("rstmid_ram_en", ram_en, 0);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_no_resp", s_rvalid, 0);
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h00010);
        wait_r(8'hA5, OKAY, 1'b1);

`ifdef AXI_RAM_ADDR_CHECK_EN
        op0 = op_cnt;
        issue(1'b1, 1'b1, 1'b0, 19'h00400, 8'h99, 1'b1, '0);
        wait_b(SLVERR, 1'b0);
        chk("oob_no_op", op_cnt, op0);
        chk("oob_mem", mem[10'h000], 8'h00);
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h00400);
        wait_r(8'h00, SLVERR, 1'b0);
        issue(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 19'h003FF);
        wait_r(8'h00, OKAY, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
